// File: rtl/cell_histogram_gen_pkg.sv
// Shared parameters and helpers for the HOG cell histogram builder.
// Covers bin slot placement, packed histogram width and counter widths.
package cell_histogram_gen_pkg;

    localparam int NUM_BINS_DEFAULT = 9;

    // Bit offset of a bin slot inside the packed histogram (sum bin sits at slot NUM_BINS).
    function automatic int bin_slot(input int bin, input int acc_width);
        return bin * acc_width;
    endfunction

    function automatic int hist_width_calc(input int num_bins, input int acc_width);
        return (num_bins + 1) * acc_width;
    endfunction

    // A counter over a single value still needs one bit so ports never collapse to zero width.
    function automatic int cnt_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/cell_histogram_gen_if.sv
// Pixel input and histogram output channels of the cell histogram builder.
// The master side feeds pixels and drains histograms; the slave side is the builder.
interface cell_histogram_gen_if
    import cell_histogram_gen_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int CELL_W       = 8,
    parameter int CELL_H       = 8,
    parameter int NUM_BINS     = NUM_BINS_DEFAULT
);
    localparam int ACC_WIDTH  = DATA_WIDTH + $clog2(CELL_W * CELL_H);
    localparam int HIST_WIDTH = hist_width_calc(NUM_BINS, ACC_WIDTH);
    localparam int X_WIDTH    = cnt_width(IMAGE_WIDTH / CELL_W);
    localparam int Y_WIDTH    = cnt_width(IMAGE_HEIGHT / CELL_H);

    logic                  in_valid;
    logic                  in_ready;
    logic                  in_sof;
    logic [DATA_WIDTH-1:0] magnitude;
    logic [3:0]            bin_index;
    logic                  out_valid;
    logic                  out_ready;
    logic [HIST_WIDTH-1:0] hist;
    logic [X_WIDTH-1:0]    cell_x;
    logic [Y_WIDTH-1:0]    cell_y;
    logic                  out_last;
    logic                  bin_err;

    modport master (
        output in_valid, in_sof, magnitude, bin_index, out_ready,
        input  in_ready, out_valid, hist, cell_x, cell_y, out_last, bin_err
    );

    modport slave (
        input  in_valid, in_sof, magnitude, bin_index, out_ready,
        output in_ready, out_valid, hist, cell_x, cell_y, out_last, bin_err
    );

endinterface

// File: rtl/cell_histogram_gen_mem.sv
// Partial-sum store holding one packed histogram per cell column of the current cell row.
// Asynchronous read, synchronous write, deliberately never cleared.
module hist_cell_mem #(
    parameter int DEPTH  = 80,
    parameter int WIDTH  = 140,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cell_histogram_gen.sv
// Streaming HOG cell histogram builder: accumulates raster-order (magnitude, bin) pixels
// into per-cell histograms and emits one packed histogram per CELL_W x CELL_H cell.
module cell_histogram_gen
    import cell_histogram_gen_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int CELL_W       = 8,
    parameter int CELL_H       = 8,
    parameter int NUM_BINS     = NUM_BINS_DEFAULT
) (
    input logic                 clk,
    input logic                 rst,
    cell_histogram_gen_if.slave bus
);

    localparam int ACC_WIDTH     = DATA_WIDTH + $clog2(CELL_W * CELL_H);
    localparam int HIST_WIDTH    = hist_width_calc(NUM_BINS, ACC_WIDTH);
    localparam int CELLS_PER_ROW = IMAGE_WIDTH / CELL_W;
    localparam int CELLS_PER_COL = IMAGE_HEIGHT / CELL_H;
    localparam int COL_W         = cnt_width(CELL_W);
    localparam int IDX_W         = cnt_width(CELLS_PER_ROW);
    localparam int ROW_W         = cnt_width(CELL_H);
    localparam int CROW_W        = cnt_width(CELLS_PER_COL);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(CELL_W - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(CELLS_PER_ROW - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(CELL_H - 1);
    localparam logic [CROW_W-1:0] CROW_LAST = CROW_W'(CELLS_PER_COL - 1);

    logic [COL_W-1:0]  col_in_cell, col_eff, col_nxt;
    logic [IDX_W-1:0]  cell_idx, idx_eff, idx_nxt;
    logic [ROW_W-1:0]  row_in_cell, row_eff, row_nxt;
    logic [CROW_W-1:0] cell_row, crow_eff, crow_nxt;

    logic last_col, last_idx, last_row, last_crow;
    logic in_ready, accept, drain, cell_done, bad_bin, mem_we;

    logic [HIST_WIDTH-1:0] acc_reg, mem_rdata, base_hist, next_hist, hist_reg;
    logic [IDX_W-1:0]      cell_x_reg;
    logic [CROW_W-1:0]     cell_y_reg;
    logic                  out_valid_reg, out_last_reg, bin_err_reg;

    assign in_ready  = ~out_valid_reg | bus.out_ready;
    assign accept    = bus.in_valid & in_ready;
    assign drain     = out_valid_reg & bus.out_ready;
    assign bad_bin   = int'(bus.bin_index) >= NUM_BINS;

    // A start-of-frame pixel is processed as if the counters already sat at the frame origin.
    always_comb begin
        col_eff  = col_in_cell;
        idx_eff  = cell_idx;
        row_eff  = row_in_cell;
        crow_eff = cell_row;
        if (bus.in_sof) begin
            col_eff  = '0;
            idx_eff  = '0;
            row_eff  = '0;
            crow_eff = '0;
        end
    end

    assign last_col  = (col_eff == COL_LAST);
    assign last_idx  = (idx_eff == IDX_LAST);
    assign last_row  = (row_eff == ROW_LAST);
    assign last_crow = (crow_eff == CROW_LAST);
    assign cell_done = accept & last_col & last_row;
    assign mem_we    = accept & last_col & ~last_row & ~rst;

    always_comb begin
        col_nxt  = col_eff + 1'b1;
        idx_nxt  = idx_eff;
        row_nxt  = row_eff;
        crow_nxt = crow_eff;
        if (last_col) begin
            col_nxt = '0;
            if (last_idx) begin
                idx_nxt = '0;
                if (last_row) begin
                    row_nxt  = '0;
                    crow_nxt = last_crow ? '0 : crow_eff + 1'b1;
                end else begin
                    row_nxt = row_eff + 1'b1;
                end
            end else begin
                idx_nxt = idx_eff + 1'b1;
            end
        end
    end

    // The first pixel of a cell starts from zero; the first pixel of each later cell row
    // resumes that cell's partial sums from memory; all others chain through acc_reg.
    always_comb begin
        if (col_eff == '0 && row_eff == '0) begin
            base_hist = '0;
        end else if (col_eff == '0) begin
            base_hist = mem_rdata;
        end else begin
            base_hist = acc_reg;
        end
    end

    always_comb begin
        next_hist = base_hist;
        for (int b = 0; b < NUM_BINS; b++) begin
            if (bus.bin_index == 4'(b)) begin
                next_hist[bin_slot(b, ACC_WIDTH) +: ACC_WIDTH] =
                    base_hist[bin_slot(b, ACC_WIDTH) +: ACC_WIDTH] + ACC_WIDTH'(bus.magnitude);
            end
        end
        next_hist[bin_slot(NUM_BINS, ACC_WIDTH) +: ACC_WIDTH] =
            base_hist[bin_slot(NUM_BINS, ACC_WIDTH) +: ACC_WIDTH] + ACC_WIDTH'(bus.magnitude);
    end

    hist_cell_mem #(
        .DEPTH  (CELLS_PER_ROW),
        .WIDTH  (HIST_WIDTH),
        .ADDR_W (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (idx_eff),
        .wdata (next_hist),
        .raddr (idx_eff),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            col_in_cell   <= '0;
            cell_idx      <= '0;
            row_in_cell   <= '0;
            cell_row      <= '0;
            acc_reg       <= '0;
            hist_reg      <= '0;
            cell_x_reg    <= '0;
            cell_y_reg    <= '0;
            out_last_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            bin_err_reg   <= 1'b0;
        end else begin
            if (accept) begin
                col_in_cell <= col_nxt;
                cell_idx    <= idx_nxt;
                row_in_cell <= row_nxt;
                cell_row    <= crow_nxt;
                if (!last_col) begin
                    acc_reg <= next_hist;
                end
                if (bad_bin) begin
                    bin_err_reg <= 1'b1;
                end
            end
            // A completion in the same cycle as a drain reloads the output with no bubble.
            if (cell_done) begin
                hist_reg      <= next_hist;
                cell_x_reg    <= idx_eff;
                cell_y_reg    <= crow_eff;
                out_last_reg  <= last_idx & last_crow;
                out_valid_reg <= 1'b1;
            end else if (drain) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.hist      = hist_reg;
    assign bus.cell_x    = cell_x_reg;
    assign bus.cell_y    = cell_y_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.bin_err   = bin_err_reg;

endmodule

// File: tb/tb_cell_histogram_gen.sv
// Scoreboard bench for cell_histogram_gen on a 16x16 image of 8x8 cells (four cells per frame).
// Expected histograms are queued when a frame is issued and popped by an independent monitor.
module tb_cell_histogram_gen;
    import cell_histogram_gen_pkg::*;

    localparam int DW  = 8;
    localparam int IW  = 16;
    localparam int IH  = 16;
    localparam int CW  = 8;
    localparam int CH  = 8;
    localparam int NB  = 9;
    localparam int ACC = DW + $clog2(CW * CH);
    localparam int HW  = (NB + 1) * ACC;

    typedef struct {
        logic [HW-1:0] hist;
        logic          cx;
        logic          cy;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   stall_pending = 1'b0;

    always #5 clk = ~clk;

    cell_histogram_gen_if #(
        .DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH),
        .CELL_W(CW), .CELL_H(CH), .NUM_BINS(NB)
    ) bus ();

    cell_histogram_gen #(
        .DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH),
        .CELL_W(CW), .CELL_H(CH), .NUM_BINS(NB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string name, input logic [HW-1:0] actual,
                               input logic [HW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [HW-1:0] pack_hist(input int bin, input int val, input int sum);
        logic [HW-1:0] h;
        h = '0;
        h[bin * ACC +: ACC] = ACC'(val);
        h[NB * ACC +: ACC]  = ACC'(sum);
        return h;
    endfunction

    task automatic push_exp(input logic [HW-1:0] h, input int cx, input int cy);
        exp_t e;
        e.hist = h;
        e.cx   = 1'(cx);
        e.cy   = 1'(cy);
        e.last = (cx == 1 && cy == 1);
        exp_q.push_back(e);
    endtask

    task automatic push_uniform(input int bin, input int val);
        for (int cy = 0; cy < 2; cy++)
            for (int cx = 0; cx < 2; cx++)
                push_exp(pack_hist(bin, val, val), cx, cy);
    endtask

    function automatic int pix_mag(input int mode, input int x, input int y);
        case (mode)
            1: return 1;
            2: return (y < 8) ? 2 : 3;
            4: return 255;
            5: return (x == 0 && y == 0) ? 7 : 1;
            default: return 5;
        endcase
    endfunction

    function automatic int pix_bin(input int mode, input int x, input int y);
        case (mode)
            1: return 3;
            2: return (y < 8) ? 0 : 5;
            4: return 8;
            5: return (x == 0 && y == 0) ? 12 : 0;
            default: return 7;
        endcase
    endfunction

    // Holds one pixel on the bus until it is accepted; one pixel per cycle when unstalled.
    task automatic applyStimulus(input int mag, input int bin, input bit sof);
        bit accepted = 1'b0;
        int waited   = 0;
        bus.in_valid  = 1'b1;
        bus.magnitude = DW'(mag);
        bus.bin_index = 4'(bin);
        bus.in_sof    = sof;
        while (!accepted && waited < 200) begin
            @(negedge clk);
            accepted = bus.in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!accepted) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: in_ready stayed %0b, expected 1", bus.in_ready);
        end
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int mode, input bit sof_first, input int npix);
        for (int i = 0; i < npix; i++) begin
            applyStimulus(pix_mag(mode, i % IW, i / IW), pix_bin(mode, i % IW, i / IW),
                          sof_first && (i == 0));
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d outputs outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every output handshake pops and checks the oldest expected histogram.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_output: got hist %0h, expected none", bus.hist);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("hist", bus.hist, e.hist);
                    checkOutput("cell_x", HW'(bus.cell_x), HW'(e.cx));
                    checkOutput("cell_y", HW'(bus.cell_y), HW'(e.cy));
                    checkOutput("out_last", HW'(bus.out_last), HW'(e.last));
                end
            end
        end
    end

    // Back-pressure: holds out_ready low for 20 cycles once the first armed output appears.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_pending && bus.out_valid) begin
                stall_pending = 1'b0;
                bus.out_ready = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    checkOutput("stall_in_ready", HW'(bus.in_ready), HW'(0));
                    checkOutput("stall_out_valid", HW'(bus.out_valid), HW'(1));
                    if (exp_q.size() != 0) begin
                        checkOutput("stall_hist", bus.hist, exp_q[0].hist);
                    end else begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL stall_hist: got %0h, expected a queued cell", bus.hist);
                    end
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.magnitude = '0;
        bus.bin_index = '0;
        bus.out_ready = 1'b1;
        do_reset();

        $display("[TB] reset state");
        checkOutput("rst_out_valid", HW'(bus.out_valid), HW'(0));
        checkOutput("rst_hist", bus.hist, '0);
        checkOutput("rst_cell_x", HW'(bus.cell_x), HW'(0));
        checkOutput("rst_cell_y", HW'(bus.cell_y), HW'(0));
        checkOutput("rst_out_last", HW'(bus.out_last), HW'(0));
        checkOutput("rst_bin_err", HW'(bus.bin_err), HW'(0));
        checkOutput("rst_in_ready", HW'(bus.in_ready), HW'(1));

        $display("[TB] uniform mag 1 bin 3");
        push_uniform(3, 64);
        send_frame(1, 1'b1, IW * IH);
        wait_drain();

        $display("[TB] two cell rows with different bins");
        push_exp(pack_hist(0, 128, 128), 0, 0);
        push_exp(pack_hist(0, 128, 128), 1, 0);
        push_exp(pack_hist(5, 192, 192), 0, 1);
        push_exp(pack_hist(5, 192, 192), 1, 1);
        send_frame(2, 1'b1, IW * IH);
        wait_drain();

        $display("[TB] back-pressure on first output");
        push_uniform(3, 64);
        stall_pending = 1'b1;
        send_frame(1, 1'b1, IW * IH);
        wait_drain();

        $display("[TB] full-scale magnitudes");
        push_uniform(8, 16320);
        send_frame(4, 1'b1, IW * IH);
        wait_drain();
        checkOutput("bin_err_clean", HW'(bus.bin_err), HW'(0));

        $display("[TB] out-of-range bin");
        push_exp(pack_hist(0, 63, 70), 0, 0);
        push_exp(pack_hist(0, 64, 64), 1, 0);
        push_exp(pack_hist(0, 64, 64), 0, 1);
        push_exp(pack_hist(0, 64, 64), 1, 1);
        send_frame(5, 1'b1, IW * IH);
        wait_drain();
        checkOutput("bin_err_set", HW'(bus.bin_err), HW'(1));
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bin_err_sticky", HW'(bus.bin_err), HW'(1));
        do_reset();
        checkOutput("bin_err_cleared", HW'(bus.bin_err), HW'(0));

        $display("[TB] start of frame mid-frame");
        send_frame(6, 1'b0, 3 * IW + 20);
        push_uniform(3, 64);
        send_frame(1, 1'b1, IW * IH);
        wait_drain();

        $display("[TB] reset mid-frame");
        send_frame(6, 1'b0, 40);
        do_reset();
        push_uniform(3, 64);
        send_frame(1, 1'b0, IW * IH);
        wait_drain();

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
